// File: rtl/tl_channel_buffer.sv
// Purpose: TileLink-UL A/D channel buffer; each direction is an independent, bit-exact FIFO.
// Latency: one cycle per queue (zero with FLOW while empty, or DEPTH=0 wire-through).
// Backpressure: in_ready drops when a queue is full (PIPE lets a full queue refill as it drains); reset low gates both handshakes.

module tl_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int PIPE  = 0,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_bits,
    output logic [CNT_W-1:0] count
);

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage: the channel is a plain wire and ignores reset.
            assign out_valid = in_valid;
            assign out_bits  = in_bits;
            assign in_ready  = out_ready;
            assign count     = '0;

            logic unused_ctl;
            assign unused_ctl = clock ^ reset;
        end else begin : g_ring
            localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

            logic [W-1:0]  mem [DEPTH];
            logic [PW-1:0] enq_ptr;
            logic [PW-1:0] deq_ptr;
            logic          maybe_full;
            logic          ptr_eq;
            logic          empty;
            logic          full;
            logic          bypass;
            logic          enq;
            logic          deq;
            logic          do_enq;
            logic          do_deq;
            int            occ;

            // Pointers wrap explicitly so non-power-of-2 depths work.
            function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
                return (p == LAST) ? '0 : p + 1'b1;
            endfunction

            assign ptr_eq = (enq_ptr == deq_ptr);
            assign empty  = ptr_eq && !maybe_full;
            assign full   = ptr_eq && maybe_full;
            assign bypass = (FLOW != 0) && empty;

            // Handshake, gated off while reset is held low.
            always_comb begin
                out_valid = reset && (!empty || (bypass && in_valid));
                in_ready  = reset && (!full || ((PIPE != 0) && out_ready));
                out_bits  = bypass ? in_bits : mem[deq_ptr];
            end

            assign enq = in_valid && in_ready;
            assign deq = out_valid && out_ready;
            // A flow-through beat taken in the same cycle never touches storage.
            assign do_enq = enq && !(bypass && deq);
            assign do_deq = deq && !bypass;

            // Occupancy derived from the pointer distance; equal pointers are resolved by maybe_full.
            always_comb begin
                occ = int'(enq_ptr) - int'(deq_ptr);
                if (occ < 0) occ = occ + DEPTH;
                if (full) occ = DEPTH;
            end
            assign count = CNT_W'(occ);

            // Pointer and fullness state; storage itself is never cleared.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    enq_ptr    <= '0;
                    deq_ptr    <= '0;
                    maybe_full <= 1'b0;
                end else begin
                    if (do_enq) enq_ptr <= bump(enq_ptr);
                    if (do_deq) deq_ptr <= bump(deq_ptr);
                    if (do_enq != do_deq) maybe_full <= do_enq;
                end
            end

            // Beat storage written at the enqueue pointer.
            always_ff @(posedge clock) begin
                if (do_enq) mem[enq_ptr] <= in_bits;
            end
        end
    endgenerate

endmodule

module tl_channel_buffer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 30,
    parameter int SIZE_W  = 3,
    parameter int SRC_W   = 3,
    parameter int SINK_W  = 1,
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int A_FLOW  = 0,
    parameter int D_FLOW  = 0,
    parameter int A_PIPE  = 0,
    parameter int D_PIPE  = 0,
    localparam int MASK_W  = DATA_W / 8,
    // A beat: opcode, param, size, source, address, mask, data, corrupt
    localparam int AW      = 3 + 3 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W + 1,
    // D beat: opcode, param, size, source, sink, denied, data, corrupt
    localparam int DW      = 3 + 2 + SIZE_W + SRC_W + SINK_W + 1 + DATA_W + 1,
    localparam int A_CNT_W = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int D_CNT_W = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               a_in_valid,
    output logic               a_in_ready,
    input  logic [AW-1:0]      a_in_bits,
    output logic               a_out_valid,
    input  logic               a_out_ready,
    output logic [AW-1:0]      a_out_bits,
    input  logic               d_in_valid,
    output logic               d_in_ready,
    input  logic [DW-1:0]      d_in_bits,
    output logic               d_out_valid,
    input  logic               d_out_ready,
    output logic [DW-1:0]      d_out_bits,
    output logic [A_CNT_W-1:0] a_count,
    output logic [D_CNT_W-1:0] d_count
);

    // Requests flow master to slave.
    tl_queue #(
        .W(AW), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .CNT_W(A_CNT_W)
    ) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bits   (a_in_bits),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_bits  (a_out_bits),
        .count     (a_count)
    );

    // Responses flow slave to master.
    tl_queue #(
        .W(DW), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .CNT_W(D_CNT_W)
    ) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_bits   (d_in_bits),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_bits  (d_out_bits),
        .count     (d_count)
    );

endmodule

// File: tb/tb_tl_channel_buffer.sv
// Bench for tl_channel_buffer: three configurations viewed as six channels.
// Channels: 0/1 = default A/D, 2 = A with FLOW, 3 = D with PIPE, 4 = 64-bit A wire-through, 5 = 64-bit D depth 3.
// Reference model is a beat queue per channel driven by the handshake rules.

module tb_tl_channel_buffer;

    localparam int WM  = 115;
    localparam int AW0 = 79;
    localparam int DW0 = 46;
    localparam int AW2 = 115;
    localparam int DW2 = 78;

    localparam int DEP [6] = '{2, 2, 2, 2, 0, 3};
    localparam int FLO [6] = '{0, 0, 1, 0, 0, 0};
    localparam int PIP [6] = '{0, 0, 0, 1, 0, 0};
    localparam int CW  [6] = '{AW0, DW0, AW0, DW0, AW2, DW2};

    logic clock = 1'b0;
    logic rst_n = 1'b1;

    logic          ch_iv  [6];
    logic          ch_or  [6];
    logic [WM-1:0] ch_ib  [6];
    logic          ch_ir  [6];
    logic          ch_ov  [6];
    logic [WM-1:0] ch_ob  [6];
    logic [1:0]    ch_cnt [6];

    logic [AW0-1:0] u0_aob, u1_aob;
    logic [DW0-1:0] u0_dob, u1_dob;
    logic [AW2-1:0] u2_aob;
    logic [DW2-1:0] u2_dob;
    logic [1:0]     u0_ac, u0_dc, u1_ac, u1_dc, u2_dc;
    logic           u2_ac;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    tl_channel_buffer u0 (
        .clock(clock), .reset(rst_n),
        .a_in_valid(ch_iv[0]), .a_in_ready(ch_ir[0]), .a_in_bits(ch_ib[0][AW0-1:0]),
        .a_out_valid(ch_ov[0]), .a_out_ready(ch_or[0]), .a_out_bits(u0_aob),
        .d_in_valid(ch_iv[1]), .d_in_ready(ch_ir[1]), .d_in_bits(ch_ib[1][DW0-1:0]),
        .d_out_valid(ch_ov[1]), .d_out_ready(ch_or[1]), .d_out_bits(u0_dob),
        .a_count(u0_ac), .d_count(u0_dc)
    );

    tl_channel_buffer #(.A_FLOW(1), .D_PIPE(1), .D_DEPTH(2)) u1 (
        .clock(clock), .reset(rst_n),
        .a_in_valid(ch_iv[2]), .a_in_ready(ch_ir[2]), .a_in_bits(ch_ib[2][AW0-1:0]),
        .a_out_valid(ch_ov[2]), .a_out_ready(ch_or[2]), .a_out_bits(u1_aob),
        .d_in_valid(ch_iv[3]), .d_in_ready(ch_ir[3]), .d_in_bits(ch_ib[3][DW0-1:0]),
        .d_out_valid(ch_ov[3]), .d_out_ready(ch_or[3]), .d_out_bits(u1_dob),
        .a_count(u1_ac), .d_count(u1_dc)
    );

    tl_channel_buffer #(.DATA_W(64), .A_DEPTH(0), .D_DEPTH(3)) u2 (
        .clock(clock), .reset(rst_n),
        .a_in_valid(ch_iv[4]), .a_in_ready(ch_ir[4]), .a_in_bits(ch_ib[4][AW2-1:0]),
        .a_out_valid(ch_ov[4]), .a_out_ready(ch_or[4]), .a_out_bits(u2_aob),
        .d_in_valid(ch_iv[5]), .d_in_ready(ch_ir[5]), .d_in_bits(ch_ib[5][DW2-1:0]),
        .d_out_valid(ch_ov[5]), .d_out_ready(ch_or[5]), .d_out_bits(u2_dob),
        .a_count(u2_ac), .d_count(u2_dc)
    );

    assign ch_ob[0]  = WM'(u0_aob);
    assign ch_ob[1]  = WM'(u0_dob);
    assign ch_ob[2]  = WM'(u1_aob);
    assign ch_ob[3]  = WM'(u1_dob);
    assign ch_ob[4]  = WM'(u2_aob);
    assign ch_ob[5]  = WM'(u2_dob);
    assign ch_cnt[0] = u0_ac;
    assign ch_cnt[1] = u0_dc;
    assign ch_cnt[2] = u1_ac;
    assign ch_cnt[3] = u1_dc;
    assign ch_cnt[4] = {1'b0, u2_ac};
    assign ch_cnt[5] = u2_dc;

    function automatic logic [WM-1:0] rand_beat(input int c);
        logic [127:0] r;
        logic [WM-1:0] m;
        r = {$urandom, $urandom, $urandom, $urandom};
        m = {WM{1'b1}} >> (WM - CW[c]);
        return WM'(r) & m;
    endfunction

    // 32-bit A beat: address sits above mask(4)+data(32)+corrupt(1).
    function automatic logic [WM-1:0] a_beat32(input logic [29:0] addr, input logic [31:0] data);
        return (WM'(addr) << 37) | (WM'(data) << 1);
    endfunction

    task automatic idle_all();
        for (int c = 0; c < 6; c++) begin
            ch_iv[c] = 1'b0;
            ch_or[c] = 1'b0;
            ch_ib[c] = '0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ch_iv[c] = 1'b1;
            ch_or[c] = 1'b1;
            ch_ib[c] = rand_beat(c);
        end
        @(negedge clock);
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (ch_ir[c] !== (DEP[c] == 0)) $display("FAIL reset_in_ready ch%0d: got %b want %b", c, ch_ir[c], DEP[c] == 0);
            else n_pass++;
            n_checks++;
            if (ch_ov[c] !== (DEP[c] == 0)) $display("FAIL reset_out_valid ch%0d: got %b want %b", c, ch_ov[c], DEP[c] == 0);
            else n_pass++;
        end
        @(posedge clock); #1;
        ch_or[4] = 1'b0;
        @(negedge clock);
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (ch_cnt[c] !== 2'd0) $display("FAIL reset_count ch%0d: got %0d want 0", c, ch_cnt[c]);
            else n_pass++;
        end
        n_checks++;
        if (ch_ir[4] !== 1'b0) $display("FAIL reset_wire_ready: got %b want 0", ch_ir[4]);
        else n_pass++;
        @(posedge clock); #1;
        rst_n = 1'b1;
        idle_all();
        @(negedge clock);
        for (int c = 0; c < 6; c++) begin
            if (DEP[c] > 0) begin
                n_checks++;
                if (ch_ir[c] !== 1'b1 || ch_ov[c] !== 1'b0)
                    $display("FAIL post_reset ch%0d: got ready=%b valid=%b want ready=1 valid=0", c, ch_ir[c], ch_ov[c]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_a_backpressure();
        logic [WM-1:0] b [3];
        b[0] = a_beat32(30'h100, 32'h1111_0000);
        b[1] = a_beat32(30'h104, 32'h2222_0000);
        b[2] = a_beat32(30'h108, 32'h3333_0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            ch_iv[0] = 1'b1;
            ch_ib[0] = b[i];
            ch_or[0] = 1'b0;
            @(negedge clock);
            n_checks++;
            if (int'(ch_cnt[0]) !== i) $display("FAIL bp_count beat%0d: got %0d want %0d", i, ch_cnt[0], i);
            else n_pass++;
            n_checks++;
            if (ch_ir[0] !== (i < 2)) $display("FAIL bp_in_ready beat%0d: got %b want %b", i, ch_ir[0], i < 2);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (ch_ov[0] !== 1'b1 || ch_ob[0] !== b[0])
                    $display("FAIL bp_head beat%0d: got v=%b %h want v=1 %h", i, ch_ov[0], ch_ob[0], b[0]);
                else n_pass++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            ch_iv[0] = 1'b0;
            ch_or[0] = 1'b1;
            @(negedge clock);
            if (i < 2) begin
                n_checks++;
                if (ch_ov[0] !== 1'b1 || ch_ob[0] !== b[i])
                    $display("FAIL bp_drain%0d: got v=%b %h want v=1 %h", i, ch_ov[0], ch_ob[0], b[i]);
                else n_pass++;
            end else begin
                n_checks++;
                if (ch_ov[0] !== 1'b0 || ch_cnt[0] !== 2'd0)
                    $display("FAIL bp_empty: got v=%b cnt=%0d want v=0 cnt=0", ch_ov[0], ch_cnt[0]);
                else n_pass++;
            end
        end
        idle_all();
    endtask

    task automatic test_a_flow();
        logic [WM-1:0] b;
        b = a_beat32(30'h200, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        ch_iv[2] = 1'b1;
        ch_ib[2] = b;
        ch_or[2] = 1'b1;
        @(negedge clock);
        n_checks++;
        if (ch_ov[2] !== 1'b1 || ch_ob[2] !== b || ch_ir[2] !== 1'b1)
            $display("FAIL flow_same_cycle: got v=%b r=%b %h want v=1 r=1 %h", ch_ov[2], ch_ir[2], ch_ob[2], b);
        else n_pass++;
        @(posedge clock); #1;
        ch_iv[2] = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ch_cnt[2] !== 2'd0 || ch_ov[2] !== 1'b0)
            $display("FAIL flow_no_store: got cnt=%0d v=%b want cnt=0 v=0", ch_cnt[2], ch_ov[2]);
        else n_pass++;
        idle_all();
    endtask

    task automatic test_d_pipe();
        logic [WM-1:0] b [3];
        for (int i = 0; i < 3; i++) b[i] = rand_beat(3);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            ch_iv[3] = 1'b1;
            ch_ib[3] = b[i];
            ch_or[3] = 1'b0;
        end
        @(posedge clock); #1;
        ch_ib[3] = b[2];
        ch_or[3] = 1'b1;
        @(negedge clock);
        n_checks++;
        if (ch_cnt[3] !== 2'd2 || ch_ir[3] !== 1'b1 || ch_ob[3] !== b[0])
            $display("FAIL pipe_full: got cnt=%0d r=%b %h want cnt=2 r=1 %h", ch_cnt[3], ch_ir[3], ch_ob[3], b[0]);
        else n_pass++;
        for (int i = 1; i < 3; i++) begin
            @(posedge clock); #1;
            ch_iv[3] = 1'b0;
            @(negedge clock);
            n_checks++;
            if (int'(ch_cnt[3]) !== 3 - i || ch_ov[3] !== 1'b1 || ch_ob[3] !== b[i])
                $display("FAIL pipe_order%0d: got cnt=%0d v=%b %h want cnt=%0d v=1 %h",
                         i, ch_cnt[3], ch_ov[3], ch_ob[3], 3 - i, b[i]);
            else n_pass++;
        end
        @(posedge clock); #1;
        idle_all();
    endtask

    // D beat at 64 bits: source sits above sink(1)+denied(1)+data(64)+corrupt(1).
    task automatic test_d_depth3_order();
        int sent;
        int got;
        int cyc;
        logic [WM-1:0] bq [$];
        logic [WM-1:0] nb;
        logic          ok;
        sent = 0;
        got  = 0;
        cyc  = 0;
        ok   = 1'b1;
        nb   = (WM'(0) << 67) | (WM'(0) << 1);
        while (got < 10 && cyc < 300) begin
            @(posedge clock); #1;
            ch_iv[5] = (sent < 10);
            ch_ib[5] = nb;
            ch_or[5] = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            if (ch_cnt[5] > 2'd3) ok = 1'b0;
            if (ch_ov[5] && ch_or[5]) begin
                n_checks++;
                if (bq.size() == 0 || ch_ob[5] !== bq[0])
                    $display("FAIL d3_order beat%0d: got %h", got, ch_ob[5]);
                else n_pass++;
                if (bq.size() != 0) void'(bq.pop_front());
                got++;
            end
            if (ch_iv[5] && ch_ir[5]) begin
                bq.push_back(nb);
                sent++;
                nb = (WM'(sent % 8) << 67) | (WM'(sent) << 1);
            end
            cyc++;
        end
        n_checks++;
        if (got !== 10) $display("FAIL d3_delivered: got %0d beats want 10", got);
        else n_pass++;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL d3_count_bound: count exceeded 3");
        else n_pass++;
        idle_all();
    endtask

    task automatic test_a_wire64();
        logic [WM-1:0] b;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            b = rand_beat(4);
            b[72:65] = 8'hFF;
            ch_iv[4] = 1'b1;
            ch_ib[4] = b;
            ch_or[4] = i[0];
            @(negedge clock);
            n_checks++;
            if (ch_ir[4] !== i[0] || ch_ov[4] !== 1'b1 || ch_ob[4] !== b)
                $display("FAIL wire64_%0d: got r=%b v=%b %h want r=%b v=1 %h", i, ch_ir[4], ch_ov[4], ch_ob[4], i[0], b);
            else n_pass++;
        end
        idle_all();
    endtask

    task automatic test_reset_mid_transfer();
        logic [WM-1:0] b [3];
        for (int i = 0; i < 3; i++) b[i] = a_beat32(30'h300 + 30'(i), $urandom);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            ch_iv[0] = 1'b1;
            ch_ib[0] = b[i];
            ch_or[0] = 1'b0;
        end
        @(negedge clock);
        n_checks++;
        if (ch_cnt[0] !== 2'd1) $display("FAIL mid_fill: got cnt=%0d want 1", ch_cnt[0]);
        else n_pass++;
        @(posedge clock); #1;
        rst_n = 1'b0;
        ch_ib[0] = b[2];
        ch_or[0] = 1'b1;
        @(negedge clock);
        n_checks++;
        if (ch_ir[0] !== 1'b0 || ch_ov[0] !== 1'b0)
            $display("FAIL mid_gate: got r=%b v=%b want r=0 v=0", ch_ir[0], ch_ov[0]);
        else n_pass++;
        @(posedge clock); #1;
        ch_iv[0] = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ch_cnt[0] !== 2'd0 || ch_ir[0] !== 1'b0)
            $display("FAIL mid_cleared: got cnt=%0d r=%b want cnt=0 r=0", ch_cnt[0], ch_ir[0]);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            rst_n = 1'b1;
            @(negedge clock);
            n_checks++;
            if (ch_ir[0] !== 1'b1 || ch_ov[0] !== 1'b0 || ch_cnt[0] !== 2'd0)
                $display("FAIL mid_release%0d: got r=%b v=%b cnt=%0d want r=1 v=0 cnt=0", i, ch_ir[0], ch_ov[0], ch_cnt[0]);
            else n_pass++;
        end
        idle_all();
    endtask

    task automatic test_random_stream(input int c, input int n);
        logic [WM-1:0] q [$];
        logic          e_ov, e_ir, enq, deq;
        logic [WM-1:0] e_ob;
        int            e_cnt;
        pulse_reset();
        q.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            ch_iv[c] = ($urandom_range(0, 3) != 0);
            ch_ib[c] = rand_beat(c);
            ch_or[c] = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            if (DEP[c] == 0) begin
                e_ov = ch_iv[c]; e_ir = ch_or[c]; e_ob = ch_ib[c]; e_cnt = 0;
            end else begin
                e_ov  = (q.size() > 0) || (FLO[c] != 0 && ch_iv[c]);
                e_ir  = (q.size() < DEP[c]) || (PIP[c] != 0 && ch_or[c]);
                e_ob  = (q.size() > 0) ? q[0] : ch_ib[c];
                e_cnt = q.size();
            end
            n_checks++;
            if (ch_ov[c] !== e_ov || ch_ir[c] !== e_ir)
                $display("FAIL rand_hs ch%0d cyc%0d: got v=%b r=%b want v=%b r=%b", c, i, ch_ov[c], ch_ir[c], e_ov, e_ir);
            else n_pass++;
            n_checks++;
            if (int'(ch_cnt[c]) !== e_cnt) $display("FAIL rand_cnt ch%0d cyc%0d: got %0d want %0d", c, i, ch_cnt[c], e_cnt);
            else n_pass++;
            if (e_ov) begin
                n_checks++;
                if (ch_ob[c] !== e_ob) $display("FAIL rand_bits ch%0d cyc%0d: got %h want %h", c, i, ch_ob[c], e_ob);
                else n_pass++;
            end
            enq = ch_iv[c] && e_ir;
            deq = e_ov && ch_or[c];
            if (DEP[c] > 0 && !(enq && deq && q.size() == 0)) begin
                if (deq) void'(q.pop_front());
                if (enq) q.push_back(ch_ib[c]);
            end
        end
        idle_all();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_a_backpressure();
        test_a_flow();
        test_d_pipe();
        test_d_depth3_order();
        test_a_wire64();
        test_reset_mid_transfer();
        for (int c = 0; c < 6; c++) test_random_stream(c, 300);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tl_channel_buffer.md
Name: tl_channel_buffer

Overview:
- Parametrised TileLink-UL buffer between a master port (upstream) and a slave port (downstream).
- A-channel requests travel upstream→downstream; D-channel responses travel downstream→upstream.
- Each channel has its own queue with configurable depth, bus widths, and flow/pipe modes.
- Successor to the fixed two-entry, 32-bit A/D buffer. Adds depth-0 bypass, occupancy reporting, and reset gating of the handshake.

Parameters:
- DATA_W, 32, data bus width in bits; must be a power of 2 and ≥8. Mask width MASK_W = DATA_W/8.
- ADDR_W, 30, A-channel address width.
- SIZE_W, 3, size field width.
- SRC_W, 3, source ID width.
- SINK_W, 1, D-channel sink ID width.
- A_DEPTH, 2, A queue entries; 0 = combinational wire-through.
- D_DEPTH, 2, D queue entries; 0 = combinational wire-through.
- A_FLOW, 0, when 1, an empty A queue passes its input to its output in the same cycle.
- D_FLOW, 0, same as A_FLOW, for the D queue.
- A_PIPE, 0, when 1, a full A queue accepts an input in the same cycle it dequeues.
- D_PIPE, 0, same as A_PIPE, for the D queue.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- a_in_valid  in  1  upstream A valid.
- a_in_ready  out  1  upstream A ready.
- a_in_bits  in  AW  packed A beat (layout below).
- a_out_valid  out  1  downstream A valid.
- a_out_ready  in  1  downstream A ready.
- a_out_bits  out  AW  packed A beat.
- d_in_valid  in  1  downstream D valid.
- d_in_ready  out  1  downstream D ready.
- d_in_bits  in  DW  packed D beat (layout below).
- d_out_valid  out  1  upstream D valid.
- d_out_ready  in  1  upstream D ready.
- d_out_bits  out  DW  packed D beat.
- a_count  out  clog2(A_DEPTH+1)  A queue occupancy; tied to 0 when A_DEPTH=0.
- d_count  out  clog2(D_DEPTH+1)  D queue occupancy; tied to 0 when D_DEPTH=0.

Behaviour:
- A beat layout, MSB→LSB: opcode[3], param[3], size[SIZE_W], source[SRC_W], address[ADDR_W], mask[MASK_W], data[DATA_W], corrupt[1].
- D beat layout, MSB→LSB: opcode[3], param[2], size[SIZE_W], source[SRC_W], sink[SINK_W], denied[1], data[DATA_W], corrupt[1].
- The buffer is field-agnostic: beats are stored and forwarded bit-exact. Beat order is strictly FIFO per channel. The two channels are fully independent.
- Each queue (DEPTH>0) is a circular buffer:
  - State is enq_ptr, deq_ptr (each wraps DEPTH-1→0, including non-power-of-2 depths) and a maybe_full flag.
  - empty = ptrs equal and !maybe_full; full = ptrs equal and maybe_full.
  - enq = in_valid & in_ready; deq = out_valid & out_ready.
  - Base handshake: out_valid = !empty, out_bits = mem[deq_ptr], in_ready = !full.
  - On enq != deq, maybe_full <= enq. count = entries held; at DEPTH it reads DEPTH.
- FLOW=1 while empty:
  - out_valid = in_valid and out_bits = in_bits (zero latency).
  - If out_ready is also high, the beat is not written and neither pointer moves.
- PIPE=1 while full: in_ready = out_ready, so enq and deq occur in the same cycle and count stays DEPTH.
- Latency: with FLOW=0, a beat enqueued in cycle N is visible on out at cycle N+1.
- Simultaneous enq and deq when neither empty nor full: both pointers advance and count is unchanged.
- DEPTH=0:
  - out_valid = in_valid, out_bits = in_bits, in_ready = out_ready.
  - No state. The FLOW/PIPE parameters for that channel are ignored.
- Reset low at a rising edge:
  - Pointers, maybe_full and count go to 0. Storage contents are not reset.
  - While reset is low, in_ready=0 and out_valid=0 on both queued channels. This gating applies even mid-transfer, so a beat presented in that cycle is neither accepted nor delivered.
  - The first cycle after reset deasserts: in_ready=1 and out_valid=0 (or equal to in_valid under FLOW).
- DEPTH=0 channels are not gated by reset (pure wires).
- No X-propagation: out_bits is don't-care when out_valid=0. The bench must not check it then.

Test Plan:
- Defaults (DEPTH=2, no flow/pipe), reset then A beats with address 0x0000_0100/0x0000_0104 back-to-back, a_out_ready=0 → a_count 1,2; a_in_ready=0 after the 2nd; 3rd beat held off; raising ready delivers 0x100 then 0x104 in order.
- A_FLOW=1, empty queue, a_out_ready=1, beat with data=0xDEADBEEF → a_out_valid in the same cycle with the same data; a_count stays 0.
- D_PIPE=1, D_DEPTH=2 full, d_out_ready=1, new d_in beat → d_in_ready=1, enq and deq in the same cycle, d_count remains 2, order preserved.
- D_DEPTH=3 (non-power-of-2), stream 10 beats with source IDs 0..7 wrapping under random ready → all 10 exit in order; d_count never exceeds 3.
- Reset asserted low with 2 beats stored and a_out_ready=1 → next cycle a_count=0, a_out_valid=0, a_in_ready=0 during reset; after release, a_in_ready=1 and no stale beat appears.
- A_DEPTH=0, DATA_W=64: toggle a_out_ready → a_in_ready mirrors it combinationally; a_out_bits equals a_in_bits with a 72-bit-field beat (mask 0xFF) passed unchanged.
